i2c_txn_arbiter: RTL and testbench

//  Shares one i2c_controller between NUM_REQ requesters using round-robin arbitration.
//  For each transaction it latches the granted request and drives the controller's en/addr/reg/rw/din.
//  It detects the start and end of the controller's busy pulse, then returns dout with a per-requester done pulse.
//  A watchdog aborts hung transfers and parks the block in FAULT until software clears it.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/i2c_txn_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM encoding, controller rw/mode encodings.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_DONE   = 3'd3,
      ST_GAP    = 3'd4,
      ST_ABORT  = 3'd5,
      ST_FAULT  = 3'd6
   } arb_state_e;

   localparam logic I2C_RW_WRITE = 1'b1;
   localparam logic I2C_RW_READ  = 1'b0;

   localparam logic [1:0] I2C_MODE_STANDARD  = 2'b00;
   localparam logic [1:0] I2C_MODE_FAST      = 2'b01;
   localparam logic [1:0] I2C_MODE_FAST_PLUS = 2'b10;
   localparam logic [1:0] I2C_MODE_HIGH      = 2'b11;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping back to ptr_i.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   // Scan from farthest to nearest so the nearest set request after ptr_i wins.
   always_comb begin
      int j;
      gnt_o = '0;
      idx_o = '0;
      any_o = |req_i;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = int'(ptr_i) + k;
         j = (j >= NUM_REQ) ? (j - NUM_REQ) : j;
         idx_o = req_i[j] ? IW'(j) : idx_o;
      end
      gnt_o[idx_o] = any_o;
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one i2c_controller among NUM_REQ requesters, with a
// launch/active watchdog that parks the block in FAULT until software clears it.
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 50000,
   parameter int GAP_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [7*NUM_REQ-1:0]  req_addr,
   input  logic [8*NUM_REQ-1:0]  req_reg,
   input  logic [NUM_REQ-1:0]    req_rw,
   input  logic [16*NUM_REQ-1:0] req_din,
   input  logic [1:0]            mode_cfg,
   input  logic                  fault_clr,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [15:0]           rsp_data,
   output logic                  rsp_err,
   output logic                  fault,
   output logic                  i2c_en,
   output logic [1:0]            i2c_mode,
   output logic [6:0]            i2c_addr,
   output logic [7:0]            i2c_reg,
   output logic                  i2c_rw,
   output logic [15:0]           i2c_din,
   input  logic [15:0]           i2c_dout,
   input  logic                  i2c_busy
);

   localparam int IW = $clog2(NUM_REQ);
   // The timer also paces GAP, so it must hold GAP_CYCLES-1 as well as TIMEOUT-1.
   localparam int TW = max_i(max_i($clog2(TIMEOUT), $clog2(GAP_CYCLES)), 1);

   arb_state_e           state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d, timer_inc_s;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d, rsp_valid_q, rsp_valid_d;
   logic [15:0]          rsp_data_q, rsp_data_d, din_q, din_d;
   logic                 rsp_err_q, rsp_err_d, fault_q, fault_d, en_q, en_d, rw_q, rw_d;
   logic [6:0]           addr_q, addr_d;
   logic [7:0]           reg_q, reg_d;
   logic [NUM_REQ-1:0]   arb_gnt_s;
   logic [IW-1:0]        arb_idx_s;
   logic                 arb_any_s;
   logic                 timeout_s;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt_s),
      .idx_o (arb_idx_s),
      .any_o (arb_any_s)
   );

   assign timer_inc_s = (timer_q == {TW{1'b1}}) ? timer_q : (timer_q + TW'(1));
   assign timeout_s   = (timer_q == TW'(TIMEOUT - 1));

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      fault_d     = fault_q;
      en_d        = en_q;
      addr_d      = addr_q;
      reg_d       = reg_q;
      rw_d        = rw_q;
      din_d       = din_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any_s) begin
               addr_d   = req_addr[int'(arb_idx_s)*7 +: 7];
               reg_d    = req_reg[int'(arb_idx_s)*8 +: 8];
               rw_d     = req_rw[arb_idx_s];
               din_d    = req_din[int'(arb_idx_s)*16 +: 16];
               grant_d  = arb_gnt_s;
               rr_ptr_d = arb_idx_s;
               en_d     = 1'b1;
               state_d  = ST_LAUNCH;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_LAUNCH, ST_ACTIVE: begin
            if ((state_q == ST_LAUNCH) && i2c_busy) begin
               state_d = ST_ACTIVE;
            end else if ((state_q == ST_ACTIVE) && !i2c_busy) begin
               // Drop en on this very edge so the controller does not start a new frame.
               en_d        = 1'b0;
               rsp_data_d  = i2c_dout;
               rsp_valid_d = grant_q;
               state_d     = ST_DONE;
            end else if (timeout_s) begin
               en_d        = 1'b0;
               rsp_data_d  = 16'h0000;
               rsp_valid_d = grant_q;
               rsp_err_d   = 1'b1;
               state_d     = ST_ABORT;
            end else begin
               state_d     = state_q;
            end
         end
         ST_DONE: begin
            grant_d = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (timer_q == TW'(GAP_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_ABORT: begin
            grant_d = '0;
            fault_d = 1'b1;
            state_d = ST_FAULT;
         end
         ST_FAULT: begin
            if (fault_clr && !i2c_busy) begin
               fault_d = 1'b0;
               state_d = ST_GAP;
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            en_d    = 1'b0;
            grant_d = '0;
            fault_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      timer_d = (state_d != state_q) ? '0 : timer_inc_s;
   end

   // State and output registers; reset forces i2c_en low immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         rr_ptr_q    <= IW'(NUM_REQ - 1);
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= 16'h0000;
         rsp_err_q   <= 1'b0;
         fault_q     <= 1'b0;
         en_q        <= 1'b0;
         addr_q      <= 7'h00;
         reg_q       <= 8'h00;
         rw_q        <= 1'b0;
         din_q       <= 16'h0000;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         fault_q     <= fault_d;
         en_q        <= en_d;
         addr_q      <= addr_d;
         reg_q       <= reg_d;
         rw_q        <= rw_d;
         din_q       <= din_d;
      end
   end

   assign grant     = grant_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign fault     = fault_q;
   assign i2c_en    = en_q;
   assign i2c_mode  = mode_cfg;
   assign i2c_addr  = addr_q;
   assign i2c_reg   = reg_q;
   assign i2c_rw    = rw_q;
   assign i2c_din   = din_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter; the bench plays the controller's busy/dout directly.
module tb_i2c_txn_arbiter;

   localparam int N  = 4;
   localparam int TO = 20;
   localparam int GP = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [27:0]   req_addr = '0;
   logic [31:0]   req_reg = '0;
   logic [N-1:0]  req_rw = '0;
   logic [63:0]   req_din = '0;
   logic [1:0]    mode_cfg = 2'b10;
   logic          fault_clr = 1'b0;
   logic [N-1:0]  grant, rsp_valid;
   logic [15:0]   rsp_data, i2c_din;
   logic          rsp_err, fault, i2c_en, i2c_rw;
   logic [1:0]    i2c_mode;
   logic [6:0]    i2c_addr;
   logic [7:0]    i2c_reg;
   logic [15:0]   i2c_dout = 16'h0000;
   logic          i2c_busy = 1'b0;

   int errors = 0;
   int checks = 0;
   int n;

   i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .GAP_CYCLES(GP)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_reg(req_reg), .req_rw(req_rw), .req_din(req_din), .mode_cfg(mode_cfg),
      .fault_clr(fault_clr), .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .fault(fault), .i2c_en(i2c_en), .i2c_mode(i2c_mode),
      .i2c_addr(i2c_addr), .i2c_reg(i2c_reg), .i2c_rw(i2c_rw), .i2c_din(i2c_din),
      .i2c_dout(i2c_dout), .i2c_busy(i2c_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_en(output int cnt);
      cnt = 0;
      while (i2c_en !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk("en_rise_bound", 32'(cnt < 200), 32'd1);
   endtask

   task automatic finish(input int idx, input logic [15:0] dv);
      i2c_busy = 1'b1;
      repeat (3) @(negedge clk);
      i2c_dout = dv;
      i2c_busy = 1'b0;
      @(negedge clk);
      chk("done_rsp_valid", 32'(rsp_valid), 32'(1 << idx));
      chk("done_rsp_data", 32'(rsp_data), 32'(dv));
      chk("done_rsp_err", 32'(rsp_err), 32'd0);
      chk("done_en_low", 32'(i2c_en), 32'd0);
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_grant", 32'(grant), 32'd0);
   endtask

   task automatic serve(input int idx, input logic [15:0] dv, input bit gapchk);
      int c;
      wait_en(c);
      chk("serve_grant", 32'(grant), 32'(1 << idx));
      if (gapchk) chk("serve_gap", 32'(c >= GP), 32'd1);
      finish(idx, dv);
   endtask

   initial begin
      req_addr[6:0]   = 7'h50;  req_reg[7:0]   = 8'h10; req_din[15:0]  = 16'hBEEF; req_rw[0] = 1'b1;
      req_addr[13:7]  = 7'h22;  req_reg[15:8]  = 8'h05; req_din[31:16] = 16'h0101; req_rw[1] = 1'b1;
      req_addr[20:14] = 7'h3C;  req_reg[23:16] = 8'h01; req_din[47:32] = 16'h0000; req_rw[2] = 1'b0;
      req_addr[27:21] = 7'h11;  req_reg[31:24] = 8'h77; req_din[63:48] = 16'h5A5A; req_rw[3] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_en", 32'(i2c_en), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mode_passthru", 32'(i2c_mode), 32'h2);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("clr_outside_fault", 32'(fault), 32'd0);

      // 1: single write from requester 0
      req_valid = 4'b0001;
      wait_en(n);
      chk("t1_latency", 32'(n), 32'd1);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_addr", 32'(i2c_addr), 32'h50);
      chk("t1_reg", 32'(i2c_reg), 32'h10);
      chk("t1_rw", 32'(i2c_rw), 32'd1);
      chk("t1_din", 32'(i2c_din), 32'hBEEF);
      req_addr[6:0] = 7'h7F;
      finish(0, 16'hAAAA);
      chk("t1_latched_addr", 32'(i2c_addr), 32'h50);
      req_valid = 4'b0000;

      // 2: read from requester 2
      req_valid = 4'b0100;
      wait_en(n);
      chk("t2_grant", 32'(grant), 32'h4);
      chk("t2_addr", 32'(i2c_addr), 32'h3C);
      chk("t2_reg", 32'(i2c_reg), 32'h01);
      chk("t2_rw", 32'(i2c_rw), 32'd0);
      finish(2, 16'h1234);
      req_valid = 4'b0000;

      // 4: launch timeout on requester 1 (busy never rises)
      req_valid = 4'b0010;
      wait_en(n);
      chk("t4_grant", 32'(grant), 32'h2);
      repeat (TO - 1) @(negedge clk);
      chk("t4_not_yet", 32'(rsp_valid), 32'd0);
      chk("t4_en_held", 32'(i2c_en), 32'd1);
      @(negedge clk);
      chk("t4_abort_valid", 32'(rsp_valid), 32'h2);
      chk("t4_abort_err", 32'(rsp_err), 32'd1);
      chk("t4_abort_data", 32'(rsp_data), 32'd0);
      chk("t4_abort_en", 32'(i2c_en), 32'd0);
      @(negedge clk);
      chk("t4_fault", 32'(fault), 32'd1);
      chk("t4_fault_grant", 32'(grant), 32'd0);
      chk("t4_fault_valid", 32'(rsp_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("t4_fault_no_en", 32'(i2c_en), 32'd0);
      i2c_busy = 1'b1; fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("t4_clr_busy_blocked", 32'(fault), 32'd1);
      i2c_busy = 1'b0; fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("t4_clr", 32'(fault), 32'd0);
      serve(1, 16'h0F0F, 1'b0);
      req_valid = 4'b0000;

      // 5: hang with busy stuck high, requester 3
      req_valid = 4'b1000;
      wait_en(n);
      chk("t5_grant", 32'(grant), 32'h8);
      i2c_busy = 1'b1;
      repeat (TO) @(negedge clk);
      chk("t5_not_yet", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("t5_abort_valid", 32'(rsp_valid), 32'h8);
      chk("t5_abort_err", 32'(rsp_err), 32'd1);
      chk("t5_abort_en", 32'(i2c_en), 32'd0);
      req_valid = 4'b0000;
      i2c_busy = 1'b0;
      @(negedge clk);
      chk("t5_fault", 32'(fault), 32'd1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;

      // 6: reset mid-ACTIVE, then fairness starting from index 0
      req_valid = 4'b0010;
      wait_en(n);
      chk("t6_grant", 32'(grant), 32'h2);
      i2c_busy = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_en", 32'(i2c_en), 32'd0);
      chk("t6_async_grant", 32'(grant), 32'd0);
      chk("t6_async_addr", 32'(i2c_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i2c_busy = 1'b0;
      req_valid = 4'b1111;
      serve(0, 16'h1000, 1'b0);
      serve(1, 16'h1001, 1'b1);
      serve(2, 16'h1002, 1'b1);
      serve(3, 16'h1003, 1'b1);
      serve(0, 16'h1004, 1'b1);
      serve(1, 16'h1005, 1'b1);
      serve(2, 16'h1006, 1'b1);
      serve(3, 16'h1007, 1'b1);
      req_valid = 4'b0000;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
